// File: rtl/cai_dev_endpoint_if.sv
// CAI device endpoint bus: host ring config/doorbell, descriptor fetch,
// engine result and completion write channels, plus constant ID outputs.
//
// Handshakes (desc_req, done, comp_wr): a transfer happens on a rising clk
// edge where valid and ready are both 1. Once valid is raised, the sender
// holds valid and its payload stable until that transfer edge. Ready may
// rise or fall freely and never depends on a transfer having happened.
interface cai_dev_endpoint_if #(
  parameter int ADDR_W   = 64,
  parameter int RING_W   = 32,
  parameter int CTX_W    = 16,
  parameter int STATUS_W = 32
);
  logic [ADDR_W-1:0]   submit_base;
  logic [RING_W-1:0]   submit_size;
  logic                submit_doorbell;
  logic [CTX_W-1:0]    context_sel;
  logic [ADDR_W-1:0]   comp_base;
  logic [RING_W-1:0]   comp_size;
  logic [15:0]         cai_version;
  logic [31:0]         cai_feature_bits;
  logic                comp_msg;
  logic                comp_irq;
  logic [STATUS_W-1:0] status;
  logic                desc_req_valid;
  logic                desc_req_ready;
  logic [ADDR_W-1:0]   desc_req_addr;
  logic [CTX_W-1:0]    desc_req_ctx;
  logic                done_valid;
  logic                done_ready;
  logic [7:0]          done_status;
  logic                comp_wr_valid;
  logic                comp_wr_ready;
  logic [ADDR_W-1:0]   comp_wr_addr;
  logic [31:0]         comp_wr_data;
  // Debug view of the endpoint FSM state encoding.
  logic [2:0]          fsm_state;

  // Device side (the endpoint itself).
  modport slave (
    input  submit_base, submit_size, submit_doorbell, context_sel,
    input  desc_req_ready, done_valid, done_status, comp_wr_ready,
    output comp_base, comp_size, cai_version, cai_feature_bits,
    output comp_msg, comp_irq, status,
    output desc_req_valid, desc_req_addr, desc_req_ctx,
    output done_ready, comp_wr_valid, comp_wr_addr, comp_wr_data,
    output fsm_state
  );

  // Host/fabric side.
  modport master (
    output submit_base, submit_size, submit_doorbell, context_sel,
    output desc_req_ready, done_valid, done_status, comp_wr_ready,
    input  comp_base, comp_size, cai_version, cai_feature_bits,
    input  comp_msg, comp_irq, status,
    input  desc_req_valid, desc_req_addr, desc_req_ctx,
    input  done_ready, comp_wr_valid, comp_wr_addr, comp_wr_data,
    input  fsm_state
  );
endinterface

// File: rtl/cai_dev_endpoint.sv
// CAI device endpoint: counts doorbells, walks the submit ring issuing
// descriptor fetches, waits for the engine result, posts a completion
// record to the fixed completion ring and pulses comp_msg/comp_irq.
module cai_dev_endpoint #(
  parameter int                ADDR_W       = 64,
  parameter int                RING_W       = 32,
  parameter int                CTX_W        = 16,
  parameter int                STATUS_W     = 32,
  parameter int                DESC_BYTES   = 32,
  parameter int                COMP_BYTES   = 16,
  parameter logic [ADDR_W-1:0] COMP_BASE    = 64'h0,
  parameter int                COMP_ENTRIES = 64,
  parameter int                PEND_MAX     = 255,
  parameter logic [15:0]       VERSION      = 16'h0100,
  parameter logic [31:0]       FEATURES     = 32'h0000_0001
) (
  input logic               clk,
  input logic               rst_n,
  cai_dev_endpoint_if.slave bus
);

  localparam int         TAIL_W   = (COMP_ENTRIES > 1) ? $clog2(COMP_ENTRIES) : 1;
  localparam logic [7:0] PEND_LIM = 8'(PEND_MAX);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_COMPL  = 3'd3,
    S_NOTIFY = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [RING_W-1:0] size_q;
  logic [CTX_W-1:0]  ctx_q;
  logic [7:0]        pending;
  logic              size_err;
  logic              overflow;
  logic              last_nz;
  logic [RING_W-1:0] head;
  logic [TAIL_W-1:0] tail;
  logic              db_ok;
  logic              fetch_hs;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] compl_addr;

  assign db_ok      = bus.submit_doorbell && (bus.submit_size != '0);
  assign fetch_hs   = bus.desc_req_valid && bus.desc_req_ready;
  assign fetch_addr = base_q + (ADDR_W'(head) * ADDR_W'(DESC_BYTES));
  assign compl_addr = COMP_BASE + (ADDR_W'(tail) * ADDR_W'(COMP_BYTES));

  assign bus.comp_base        = COMP_BASE;
  assign bus.comp_size        = RING_W'(COMP_ENTRIES);
  assign bus.cai_version      = VERSION;
  assign bus.cai_feature_bits = FEATURES;
  assign bus.fsm_state        = state;
  assign bus.status = STATUS_W'({head[15:0], pending, 4'b0000,
                                 last_nz, overflow, size_err,
                                 (state != S_IDLE)});

  // Doorbell intake: latch ring config, track pending work, sticky errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      size_q   <= '0;
      ctx_q    <= '0;
      pending  <= '0;
      size_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (db_ok) begin
        base_q <= bus.submit_base;
        size_q <= bus.submit_size;
        ctx_q  <= bus.context_sel;
      end
      if (bus.submit_doorbell && (bus.submit_size == '0)) size_err <= 1'b1;
      // A doorbell landing on a fetch handshake nets to zero change.
      if (db_ok && !fetch_hs) begin
        if (pending == PEND_LIM) overflow <= 1'b1;
        else                     pending  <= pending + 8'd1;
      end else if (!db_ok && fetch_hs) begin
        pending <= pending - 8'd1;
      end
    end
  end

  // Job sequencer: fetch -> wait result -> write completion -> notify.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      head               <= '0;
      tail               <= '0;
      last_nz            <= 1'b0;
      bus.desc_req_valid <= 1'b0;
      bus.desc_req_addr  <= '0;
      bus.desc_req_ctx   <= '0;
      bus.done_ready     <= 1'b0;
      bus.comp_wr_valid  <= 1'b0;
      bus.comp_wr_addr   <= '0;
      bus.comp_wr_data   <= '0;
      bus.comp_msg       <= 1'b0;
      bus.comp_irq       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pending != 8'd0) begin
            state              <= S_FETCH;
            bus.desc_req_valid <= 1'b1;
            bus.desc_req_addr  <= fetch_addr;
            bus.desc_req_ctx   <= ctx_q;
          end
        end
        S_FETCH: begin
          if (bus.desc_req_ready) begin
            state              <= S_EXEC;
            bus.desc_req_valid <= 1'b0;
            bus.done_ready     <= 1'b1;
            // A head left beyond a newly shrunk ring wraps on this step.
            head <= (head >= size_q - RING_W'(1)) ? '0 : head + RING_W'(1);
          end
        end
        S_EXEC: begin
          if (bus.done_valid) begin
            state             <= S_COMPL;
            bus.done_ready    <= 1'b0;
            last_nz           <= (bus.done_status != 8'd0);
            bus.comp_wr_valid <= 1'b1;
            bus.comp_wr_addr  <= compl_addr;
            bus.comp_wr_data  <= {bus.done_status, 8'h00, 16'(bus.desc_req_ctx)};
          end
        end
        S_COMPL: begin
          if (bus.comp_wr_ready) begin
            state             <= S_NOTIFY;
            bus.comp_wr_valid <= 1'b0;
            bus.comp_msg      <= 1'b1;
            bus.comp_irq      <= 1'b1;
            tail <= (tail == TAIL_W'(COMP_ENTRIES - 1)) ? '0 : tail + TAIL_W'(1);
          end
        end
        S_NOTIFY: begin
          bus.comp_msg <= 1'b0;
          bus.comp_irq <= 1'b0;
          if (pending != 8'd0) begin
            state              <= S_FETCH;
            bus.desc_req_valid <= 1'b1;
            bus.desc_req_addr  <= fetch_addr;
            bus.desc_req_ctx   <= ctx_q;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cai_dev_endpoint.sv
// Directed bench for cai_dev_endpoint: reset values, single job, ring wrap,
// size error, back-pressure, pending saturation and mid-job reset.
module tb_cai_dev_endpoint;

  logic clk;
  logic rst_n;
  int   n_total = 0;
  int   n_pass  = 0;

  cai_dev_endpoint_if bus ();

  cai_dev_endpoint dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_reset();
    rst_n               = 1'b0;
    bus.submit_doorbell = 1'b0;
    bus.desc_req_ready  = 1'b0;
    bus.done_valid      = 1'b0;
    bus.done_status     = 8'h00;
    bus.comp_wr_ready   = 1'b0;
    #3;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Driver tasks
  task automatic ring();
    bus.submit_doorbell = 1'b1;
    tick();
    bus.submit_doorbell = 1'b0;
  endtask

  // Serves one job starting with the FSM in FETCH.
  task automatic service(input logic [63:0] exp_addr, input logic [15:0] exp_ctx,
                         input logic [7:0] st, input logic [63:0] exp_wr,
                         input logic [7:0] exp_pend);
    chk("fetch_valid", bus.desc_req_valid, 1);
    chk("fetch_addr", bus.desc_req_addr, exp_addr);
    chk("fetch_ctx", bus.desc_req_ctx, exp_ctx);
    bus.desc_req_ready = 1'b1;
    tick();
    bus.desc_req_ready = 1'b0;
    chk("fetch_drop", bus.desc_req_valid, 0);
    chk("done_ready", bus.done_ready, 1);
    chk("pend_after_fetch", bus.status[15:8], exp_pend);
    bus.done_status = st;
    bus.done_valid  = 1'b1;
    tick();
    bus.done_valid = 1'b0;
    chk("wr_valid", bus.comp_wr_valid, 1);
    chk("wr_addr", bus.comp_wr_addr, exp_wr);
    chk("wr_data", bus.comp_wr_data, {32'h0, st, 8'h00, exp_ctx});
    bus.comp_wr_ready = 1'b1;
    tick();
    bus.comp_wr_ready = 1'b0;
    chk("irq_on", bus.comp_irq, 1);
    chk("msg_on", bus.comp_msg, 1);
    tick();
    chk("irq_off", bus.comp_irq, 0);
  endtask

  initial begin
    bus.submit_base = '0;
    bus.submit_size = '0;
    bus.context_sel = '0;
    do_reset();

    // Reset state and constants
    chk("rst_status", bus.status, 0);
    chk("rst_state", bus.fsm_state, 0);
    chk("rst_desc_valid", bus.desc_req_valid, 0);
    chk("rst_wr_valid", bus.comp_wr_valid, 0);
    chk("rst_irq", bus.comp_irq, 0);
    chk("comp_base", bus.comp_base, 64'h0);
    chk("comp_size", bus.comp_size, 64);
    chk("version", bus.cai_version, 16'h0100);
    chk("features", bus.cai_feature_bits, 32'h1);

    // Single job
    bus.submit_base = 64'h1000;
    bus.submit_size = 32'd4;
    bus.context_sel = 16'd7;
    ring();
    chk("t1_pend1", bus.status[15:8], 1);
    chk("t1_no_fetch_yet", bus.desc_req_valid, 0);
    tick();
    chk("t1_status_busy", bus.status, 32'h0000_0101);
    service(64'h1000, 16'd7, 8'h00, 64'h0, 8'd0);
    chk("t1_status_end", bus.status, 32'h0001_0000);

    // Ring wrap with size 2, three doorbells
    do_reset();
    bus.submit_base = 64'h1000;
    bus.submit_size = 32'd2;
    bus.context_sel = 16'd7;
    ring();
    ring();
    ring();
    chk("t2_pend3", bus.status[15:8], 3);
    service(64'h1000, 16'd7, 8'h00, 64'h00, 8'd2);
    service(64'h1020, 16'd7, 8'h11, 64'h10, 8'd1);
    service(64'h1000, 16'd7, 8'h00, 64'h20, 8'd0);
    chk("t2_status_end", bus.status, 32'h0001_0000);

    // Zero-size doorbell
    do_reset();
    bus.submit_size = 32'd0;
    ring();
    tick();
    chk("t3_no_fetch", bus.desc_req_valid, 0);
    chk("t3_size_err", bus.status, 32'h0000_0002);
    bus.submit_base = 64'h2000;
    bus.submit_size = 32'd4;
    bus.context_sel = 16'd3;
    ring();
    tick();
    service(64'h2000, 16'd3, 8'h05, 64'h0, 8'd0);
    chk("t3_sticky", bus.status, 32'h0001_000A);

    // Back-pressure on fetch with more doorbells
    ring();
    tick();
    for (int i = 0; i < 10; i++) begin
      bus.submit_doorbell = (i == 2 || i == 5);
      tick();
      chk("t4_addr_stable", bus.desc_req_addr, 64'h2020);
    end
    bus.submit_doorbell = 1'b0;
    chk("t4_valid_held", bus.desc_req_valid, 1);
    chk("t4_pend3", bus.status[15:8], 3);
    bus.submit_doorbell = 1'b1;
    bus.desc_req_ready  = 1'b1;
    tick();
    bus.submit_doorbell = 1'b0;
    bus.desc_req_ready  = 1'b0;
    chk("t4_pend_coincident", bus.status[15:8], 3);
    chk("t4_exec", bus.done_ready, 1);
    chk("t4_head", bus.status[31:16], 2);

    // Pending saturation
    do_reset();
    bus.submit_base = 64'h0;
    bus.submit_size = 32'd4;
    for (int i = 0; i < 255; i++) ring();
    chk("t5_pend255", bus.status[15:8], 255);
    chk("t5_no_ovf_yet", bus.status[2], 0);
    ring();
    chk("t5_pend_sat", bus.status[15:8], 255);
    chk("t5_ovf", bus.status[2], 1);

    // Reset during completion write
    do_reset();
    bus.submit_base = 64'h3000;
    bus.submit_size = 32'd4;
    bus.context_sel = 16'd9;
    ring();
    tick();
    bus.desc_req_ready = 1'b1;
    tick();
    bus.desc_req_ready = 1'b0;
    bus.done_valid     = 1'b1;
    tick();
    bus.done_valid = 1'b0;
    chk("t6_in_compl", bus.comp_wr_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_wr_async_drop", bus.comp_wr_valid, 0);
    chk("t6_status_rst", bus.status, 0);
    tick();
    rst_n = 1'b1;
    tick();
    ring();
    tick();
    chk("t6_refetch_valid", bus.desc_req_valid, 1);
    chk("t6_refetch_addr", bus.desc_req_addr, 64'h3000);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
